// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // A single-bit operand still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (clog2(w) < 1) ? 1 : clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with valid/ready handshakes on both sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         overflow
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_sr_q, a_sr_d;
    logic [W-1:0]  b_sr_q, b_sr_d;
    logic [W-1:0]  d_sr_q, d_sr_d;
    logic          br_q, br_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_msb_q, a_msb_d;
    logic          b_msb_q, b_msb_d;
    logic          ovf_q, ovf_d;

    logic          cell_d;
    logic          cell_b;
    logic [W:0]    d_shift;

    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .diff (cell_d),
        .bout (cell_b)
    );

    // Concatenate-then-slice keeps the result shift legal for W == 1.
    assign d_shift = {cell_d, d_sr_q};

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        d_sr_d    = d_sr_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    a_msb_d = a[W-1];
                    b_msb_d = b[W-1];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                d_sr_d = d_shift[W:1];
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = cell_b;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Signed overflow: operand signs differ and result sign follows b.
                    ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign diff     = d_sr_q;
    assign bout     = br_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=8 and W=1) and the full_subtractor cell.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // W=8 instance
    logic         rst, in_valid, in_ready, bin, out_valid, out_ready, bout, overflow;
    logic [W-1:0] a, b, diff;

    // W=1 instance
    logic         rst1, in_valid1, in_ready1, bin1, out_valid1, out_ready1, bout1, overflow1;
    logic [0:0]   a1, b1, diff1;

    // Standalone cell
    logic fs_a, fs_b, fs_bin, fs_diff, fs_bout;

    serial_subtractor #(.W(W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .overflow(overflow)
    );

    serial_subtractor #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .bout(bout1), .overflow(overflow1)
    );

    full_subtractor u_fs (
        .a(fs_a), .b(fs_b), .bin(fs_bin), .diff(fs_diff), .bout(fs_bout)
    );

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        exp_t       exp;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a_i, input logic [7:0] b_i, input logic bin_i);
        int   r;
        int   sr;
        exp_t e;
        r      = int'(a_i) - int'(b_i) - int'(bin_i);
        sr     = int'($signed(a_i)) - int'($signed(b_i)) - int'(bin_i);
        e.diff = r[7:0];
        e.bout = (r < 0);
        e.ovf  = (sr < -128) || (sr > 127);
        return e;
    endfunction

    task automatic accept8(input logic [7:0] a_i, input logic [7:0] b_i, input logic bin_i);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = a_i;
        b        = b_i;
        bin      = bin_i;
        @(posedge clk);
        sb_q.push_back(model(a_i, b_i, bin_i));
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        bin      = 1'($urandom);
    endtask

    task automatic wait_done8(input string tag);
        int lat = 0;
        while (!out_valid && lat < W + 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(W));
    endtask

    task automatic compare8(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_nonempty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q[0];
            check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_diff"}, 32'(diff), 32'(e.diff));
            check({tag, "_bout"}, 32'(bout), 32'(e.bout));
            check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
        end
    endtask

    task automatic release8(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        check({tag, "_released_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_released_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op8(input string tag, input logic [7:0] a_i, input logic [7:0] b_i, input logic bin_i);
        accept8(a_i, b_i, bin_i);
        wait_done8(tag);
        compare8(tag);
        release8(tag);
    endtask

    task automatic run_op1(input string tag, input logic a_i, input logic b_i, input logic bin_i,
                           input logic e_diff, input logic e_bout, input logic e_ovf);
        int lat = 0;
        check({tag, "_in_ready"}, 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        a1        = a_i;
        b1        = b_i;
        bin1      = bin_i;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        a1        = ~a_i;
        b1        = ~b_i;
        while (!out_valid1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd1);
        check({tag, "_diff"}, 32'(diff1), 32'(e_diff));
        check({tag, "_bout"}, 32'(bout1), 32'(e_bout));
        check({tag, "_overflow"}, 32'(overflow1), 32'(e_ovf));
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check({tag, "_released_in_ready"}, 32'(in_ready1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{a: 8'h35, b: 8'h12, bin: 1'b0, exp: '{diff: 8'h23, bout: 1'b0, ovf: 1'b0}};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, exp: '{diff: 8'hFF, bout: 1'b1, ovf: 1'b0}};
        vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, exp: '{diff: 8'h7F, bout: 1'b0, ovf: 1'b1}};
        vecs[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, exp: '{diff: 8'h00, bout: 1'b0, ovf: 1'b0}};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, exp: '{diff: 8'hFF, bout: 1'b1, ovf: 1'b0}};
        vecs[5] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, exp: '{diff: 8'h80, bout: 1'b1, ovf: 1'b1}};
        vecs[6] = '{a: 8'h00, b: 8'h00, bin: 1'b1, exp: '{diff: 8'hFF, bout: 1'b1, ovf: 1'b0}};
        vecs[7] = '{a: 8'h55, b: 8'hAA, bin: 1'b0, exp: '{diff: 8'hAB, bout: 1'b1, ovf: 1'b1}};

        rst = 1'b1;  in_valid = 1'b0;  a = '0;  b = '0;  bin = 1'b0;  out_ready = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0; out_ready1 = 1'b0;
        fs_a = 1'b0; fs_b = 1'b0; fs_bin = 1'b0;

        // Full-subtractor cell, all eight input combinations.
        for (int i = 0; i < 8; i++) begin
            int r;
            {fs_a, fs_b, fs_bin} = 3'(i);
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            check($sformatf("cell%0d_diff", i), 32'(fs_diff), 32'(r & 1));
            check($sformatf("cell%0d_bout", i), 32'(fs_bout), 32'(r < 0));
        end

        repeat (2) @(negedge clk);
        rst  = 1'b0;
        rst1 = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset1_in_ready", 32'(in_ready1), 32'd1);
        check("reset1_out_valid", 32'(out_valid1), 32'd0);

        // Directed vector table, expectations written by hand.
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            accept8(vecs[i].a, vecs[i].b, vecs[i].bin);
            sb_q[sb_q.size() - 1] = vecs[i].exp;
            wait_done8(tag);
            compare8(tag);
            release8(tag);
        end

        // Random operands against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            run_op8($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Backpressure in DONE with new operands offered.
        accept8(8'h3C, 8'h4D, 1'b0);
        wait_done8("bp");
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            a        = 8'($urandom);
            b        = 8'($urandom);
            bin      = 1'($urandom);
            @(negedge clk);
            compare8($sformatf("bp_hold%0d", k));
        end
        in_valid = 1'b0;
        release8("bp");
        run_op8("after_bp", 8'h9A, 8'h21, 1'b1);

        // Reset asserted on the third RUN cycle aborts the operation.
        accept8(8'hAA, 8'h55, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        run_op8("post_rst", 8'h05, 8'h07, 1'b0);
        check("post_rst_value_hint", 32'(model(8'h05, 8'h07, 1'b0).diff), 32'hFE);

        // W=1: reset during the single RUN cycle, then a few one-bit operations.
        in_valid1 = 1'b1;
        a1        = 1'b1;
        b1        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        rst1      = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        check("w1_midrst_out_valid", 32'(out_valid1), 32'd0);
        check("w1_midrst_in_ready", 32'(in_ready1), 32'd1);
        check("w1_midrst_diff", 32'(diff1), 32'd0);
        run_op1("w1_a1b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op1("w1_a0b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        run_op1("w1_a1b0bin", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
